// File: rtl/bit_serial_acc_mc.sv
// Multi-channel bit-serial shift-accumulator: NUM_CH adder-tree sums per beat, LSB-first planes,
// cfg_bits beats per round, cfg_rounds rounds per result. Define BIT_SERIAL_ACC_SAT_EN for clamping.
module bit_serial_acc_mc #(
   parameter int NUM_CH           = 4,
   parameter int ADDER_TREE_WIDTH = 8,
   parameter int MAX_BITS         = 8,
   parameter int ROUND_MAX        = 128,
   parameter int ACC_WIDTH        = 24
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clr,
   input  logic [$clog2(MAX_BITS+1)-1:0]        cfg_bits,
   input  logic                                 cfg_signed,
   input  logic [$clog2(ROUND_MAX+1)-1:0]       cfg_rounds,
   input  logic [NUM_CH*ADDER_TREE_WIDTH-1:0]   adder_tree_sum,
   input  logic                                 adder_tree_sum_vld,
   output logic                                 adder_tree_sum_rdy,
   output logic [NUM_CH*ACC_WIDTH-1:0]          bit_serial_acc,
   output logic                                 bit_serial_acc_vld,
   input  logic                                 bit_serial_acc_rdy
);

   localparam int BW = $clog2(MAX_BITS+1);
   localparam int RW = $clog2(ROUND_MAX+1);
   localparam int AW = ACC_WIDTH;
   localparam int TW = ADDER_TREE_WIDTH;

   function automatic logic signed [AW-1:0] acc_add(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
`ifdef BIT_SERIAL_ACC_SAT_EN
      logic signed [AW:0] s;
      s = {a[AW-1], a} + {b[AW-1], b};
      if (s[AW] != s[AW-1])
         return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      return s[AW-1:0];
`else
      return a + b;
`endif
   endfunction

   logic [BW-1:0]         bit_cnt, bits_q, eff_bits;
   logic [RW-1:0]         round_cnt, rounds_q, eff_rounds;
   logic                  signed_q, eff_signed;
   logic                  first, last_bit, last_round, stall, accept, final_beat;
   logic signed [AW-1:0]  work_q   [NUM_CH];
   logic signed [AW-1:0]  work_nxt [NUM_CH];
   logic [NUM_CH*AW-1:0]  acc_q;
   logic                  acc_vld_q;

   assign stall              = acc_vld_q & ~bit_serial_acc_rdy;
   assign adder_tree_sum_rdy = ~stall;
   assign accept             = adder_tree_sum_vld & ~stall & ~clr;
   assign first              = (bit_cnt == '0) && (round_cnt == '0);

   // The first beat of a group must already obey the live config (e.g. bits=1 signed).
   always_comb begin
      eff_bits   = bits_q;
      eff_rounds = rounds_q;
      eff_signed = signed_q;
      if (first) begin
         if (cfg_bits == '0)
            eff_bits = BW'(1);
         else if (cfg_bits > BW'(MAX_BITS))
            eff_bits = BW'(MAX_BITS);
         else
            eff_bits = cfg_bits;
         if (cfg_rounds == '0)
            eff_rounds = RW'(1);
         else if (cfg_rounds > RW'(ROUND_MAX))
            eff_rounds = RW'(ROUND_MAX);
         else
            eff_rounds = cfg_rounds;
         eff_signed = cfg_signed;
      end
   end

   assign last_bit   = (bit_cnt == eff_bits - BW'(1));
   assign last_round = (round_cnt == eff_rounds - RW'(1));
   assign final_beat = accept & last_bit & last_round;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [TW-1:0]        sum_k;
      logic signed [AW-1:0] ext, term_raw, term;
      assign sum_k    = adder_tree_sum[k*TW +: TW];
      assign ext      = {{(AW-TW){sum_k[TW-1]}}, sum_k};
      assign term_raw = ext << bit_cnt;
      assign term     = (eff_signed && last_bit) ? -term_raw : term_raw;
      assign work_nxt[k] = first ? term : acc_add(work_q[k], term);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         round_cnt <= '0;
         bits_q    <= BW'(1);
         rounds_q  <= RW'(1);
         signed_q  <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) work_q[k] <= '0;
      end else if (clr) begin
         bit_cnt   <= '0;
         round_cnt <= '0;
         for (int k = 0; k < NUM_CH; k++) work_q[k] <= '0;
      end else if (accept) begin
         if (first) begin
            bits_q   <= eff_bits;
            rounds_q <= eff_rounds;
            signed_q <= eff_signed;
         end
         bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
         if (last_bit)
            round_cnt <= last_round ? '0 : round_cnt + RW'(1);
         for (int k = 0; k < NUM_CH; k++) work_q[k] <= work_nxt[k];
      end
   end

   // A final beat accepted while the previous result drains keeps vld high with fresh data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         acc_vld_q <= 1'b0;
      end else if (final_beat) begin
         for (int k = 0; k < NUM_CH; k++) acc_q[k*AW +: AW] <= work_nxt[k];
         acc_vld_q <= 1'b1;
      end else if (acc_vld_q && bit_serial_acc_rdy) begin
         acc_vld_q <= 1'b0;
      end
   end

   assign bit_serial_acc     = acc_q;
   assign bit_serial_acc_vld = acc_vld_q;

endmodule

// File: tb/tb_bit_serial_acc_mc.sv
// Directed bench for bit_serial_acc_mc with two channels and a 20-bit accumulator.
module tb_bit_serial_acc_mc;

   localparam int NUM_CH = 2;
   localparam int TW     = 8;
   localparam int AW     = 20;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 clr;
   logic [3:0]           cfg_bits;
   logic                 cfg_signed;
   logic [7:0]           cfg_rounds;
   logic [NUM_CH*TW-1:0] adder_tree_sum;
   logic                 adder_tree_sum_vld;
   logic                 adder_tree_sum_rdy;
   logic [NUM_CH*AW-1:0] bit_serial_acc;
   logic                 bit_serial_acc_vld;
   logic                 bit_serial_acc_rdy;

   int total = 0;
   int bad   = 0;

   bit_serial_acc_mc #(
      .NUM_CH(NUM_CH), .ADDER_TREE_WIDTH(TW), .MAX_BITS(8), .ROUND_MAX(128), .ACC_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .cfg_bits(cfg_bits), .cfg_signed(cfg_signed), .cfg_rounds(cfg_rounds),
      .adder_tree_sum(adder_tree_sum), .adder_tree_sum_vld(adder_tree_sum_vld),
      .adder_tree_sum_rdy(adder_tree_sum_rdy),
      .bit_serial_acc(bit_serial_acc), .bit_serial_acc_vld(bit_serial_acc_vld),
      .bit_serial_acc_rdy(bit_serial_acc_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] s0, input logic [7:0] s1);
      adder_tree_sum     = {s1, s0};
      adder_tree_sum_vld = 1'b1;
      @(posedge clk);
      #1;
      adder_tree_sum_vld = 1'b0;
   endtask

   function automatic logic [31:0] ch(input int k);
      logic [NUM_CH*AW-1:0] v;
      v = bit_serial_acc;
      return 32'(v[k*AW +: AW]);
   endfunction

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      cfg_bits = 4'd4; cfg_signed = 1'b0; cfg_rounds = 8'd1;
      adder_tree_sum = '0; adder_tree_sum_vld = 1'b0; bit_serial_acc_rdy = 1'b1;
      #12;
      chk("reset_rdy", 32'(adder_tree_sum_rdy), 32'd1);
      chk("reset_vld", 32'(bit_serial_acc_vld), 32'd0);
      chk("reset_acc0", ch(0), 32'd0);
      chk("reset_acc1", ch(1), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: unsigned, 4 bits
      beat(8'd1, 8'd2); beat(8'd1, 8'd0); beat(8'd1, 8'd0);
      chk("t1_novld", 32'(bit_serial_acc_vld), 32'd0);
      beat(8'd1, 8'd1);
      chk("t1_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("t1_ch0", ch(0), 32'd15);
      chk("t1_ch1", ch(1), 32'd10);
      @(posedge clk); #1;
      chk("t1_vld_drop", 32'(bit_serial_acc_vld), 32'd0);

      // 2: signed, 4 bits
      cfg_signed = 1'b1;
      beat(8'd0, 8'd3); beat(8'd0, 8'd3); beat(8'd0, 8'd3); beat(8'd1, 8'd3);
      chk("t2_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("t2_ch0", ch(0), 32'h000FFFF8);
      chk("t2_ch1", ch(1), 32'h000FFFFD);

      // 3: bits=2, rounds=3; cfg_bits changed after first beat must be ignored
      cfg_signed = 1'b0; cfg_bits = 4'd2; cfg_rounds = 8'd3;
      beat(8'd1, 8'd1);
      cfg_bits = 4'd4; cfg_rounds = 8'd1;
      for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
      chk("t3_novld", 32'(bit_serial_acc_vld), 32'd0);
      beat(8'd1, 8'd1);
      chk("t3_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("t3_ch0", ch(0), 32'd9);
      chk("t3_ch1", ch(1), 32'd9);

      // bits=1 signed, back-to-back results keep vld high
      cfg_bits = 4'd1; cfg_signed = 1'b1; cfg_rounds = 8'd1;
      beat(8'd5, 8'hFD);
      chk("b1s_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("b1s_ch0", ch(0), 32'h000FFFFB);
      chk("b1s_ch1", ch(1), 32'd3);
      beat(8'h80, 8'h7F);
      chk("b1s2_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("b1s2_ch0", ch(0), 32'h00000080);
      chk("b1s2_ch1", ch(1), 32'h000FFF81);
      // cfg_bits=0 behaves as 1, unsigned
      cfg_bits = 4'd0; cfg_signed = 1'b0; cfg_rounds = 8'd0;
      beat(8'd5, 8'd6);
      chk("b0_ch0", ch(0), 32'd5);
      chk("b0_ch1", ch(1), 32'd6);
      @(posedge clk); #1;
      chk("b0_vld_drop", 32'(bit_serial_acc_vld), 32'd0);

      // 4: backpressure
      cfg_bits = 4'd4; cfg_rounds = 8'd1;
      beat(8'd1, 8'd1); beat(8'd1, 8'd1); beat(8'd1, 8'd1);
      bit_serial_acc_rdy = 1'b0;
      beat(8'd1, 8'd1);
      chk("t4_vld", 32'(bit_serial_acc_vld), 32'd1);
      adder_tree_sum = {8'd1, 8'd1};
      adder_tree_sum_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_rdy", 32'(adder_tree_sum_rdy), 32'd0);
         chk("t4_stall_vld", 32'(bit_serial_acc_vld), 32'd1);
         chk("t4_stall_ch0", ch(0), 32'd15);
         @(posedge clk); #1;
      end
      bit_serial_acc_rdy = 1'b1;
      @(posedge clk); #1;
      adder_tree_sum_vld = 1'b0;
      chk("t4_release_vld", 32'(bit_serial_acc_vld), 32'd0);
      beat(8'd0, 8'd0); beat(8'd0, 8'd0); beat(8'd1, 8'd1);
      chk("t4_next_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("t4_next_ch0", ch(0), 32'd9);
      chk("t4_next_ch1", ch(1), 32'd9);

      // 5: clr mid-group
      beat(8'd3, 8'd3); beat(8'd3, 8'd3);
      adder_tree_sum = {8'd7, 8'd7};
      adder_tree_sum_vld = 1'b1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; adder_tree_sum_vld = 1'b0;
      chk("t5_clr_keep_ch0", ch(0), 32'd9);
      beat(8'd1, 8'd1); beat(8'd1, 8'd1); beat(8'd1, 8'd1);
      chk("t5_clr_novld", 32'(bit_serial_acc_vld), 32'd0);
      beat(8'd1, 8'd1);
      chk("t5_clr_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("t5_clr_ch0", ch(0), 32'd15);
      chk("t5_clr_ch1", ch(1), 32'd15);

      // 5b: reset pulse mid-group
      beat(8'd3, 8'd3); beat(8'd3, 8'd3);
      rst_n = 1'b0;
      #2;
      chk("t5_rst_vld", 32'(bit_serial_acc_vld), 32'd0);
      chk("t5_rst_ch0", ch(0), 32'd0);
      chk("t5_rst_ch1", ch(1), 32'd0);
      chk("t5_rst_rdy", 32'(adder_tree_sum_rdy), 32'd1);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
      chk("t5_rst_after_vld", 32'(bit_serial_acc_vld), 32'd1);
      chk("t5_rst_after_ch0", ch(0), 32'd15);

      // 6: long group, wrap or clamp
      cfg_bits = 4'd8; cfg_rounds = 8'd17; cfg_signed = 1'b0;
      for (int i = 0; i < 135; i++) beat(8'd127, 8'd127);
      chk("t6_novld", 32'(bit_serial_acc_vld), 32'd0);
      beat(8'd127, 8'd127);
      chk("t6_vld", 32'(bit_serial_acc_vld), 32'd1);
`ifdef BIT_SERIAL_ACC_SAT_EN
      chk("t6_ch0", ch(0), 32'h0007FFFF);
      chk("t6_ch1", ch(1), 32'h0007FFFF);
`else
      chk("t6_ch0", ch(0), 32'h00086691);
      chk("t6_ch1", ch(1), 32'h00086691);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
